// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data access) in front of a single-port LC3 memory.
// One access is in flight at a time. A streak limit keeps data priority from starving fetch.
module lc3_mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MEM_LATENCY     = 1,
    parameter int DATA_STREAK_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam int WAIT_W   = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_d;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [STREAK_W-1:0] r_streak;
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_streak_full;
    logic w_pick_d;
    logic w_grant;
    logic w_last_wait;

    // Data wins ties unless it has already taken DATA_STREAK_MAX grants while fetch waited.
    assign w_streak_full = (r_streak == STREAK_W'(DATA_STREAK_MAX));
    assign w_pick_d      = d_req && !(f_req && w_streak_full);
    assign w_grant       = (r_state == S_IDLE) && !reset && (f_req || d_req);
    assign w_last_wait   = (r_state == S_WAIT) && (r_wait_cnt == WAIT_W'(MEM_LATENCY - 1));

    assign f_gnt    = w_grant && !w_pick_d;
    assign d_gnt    = w_grant && w_pick_d;
    assign f_rvalid = (r_state == S_RESP) && !r_owner_d && !reset;
    assign d_rvalid = (r_state == S_RESP) && r_owner_d && !reset;
    assign f_rdata  = r_f_rdata;
    assign d_rdata  = r_d_rdata;
    assign m_en     = (r_state == S_ISSUE);
    assign m_we     = m_en && r_we;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign busy     = (r_state != S_IDLE);

    // NOTE: the default assignment first keeps w_next from inferring a latch on any path.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (f_req || d_req) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_last_wait) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
            r_streak   <= '0;
            r_f_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (d_gnt) begin
                r_owner_d <= 1'b1;
                r_we      <= d_we;
                r_addr    <= d_addr;
                r_wdata   <= d_wdata;
                if (f_req && !w_streak_full) r_streak <= r_streak + 1'b1;
            end
            if (f_gnt) begin
                r_owner_d <= 1'b0;
                r_we      <= 1'b0;
                r_addr    <= f_addr;
                r_streak  <= '0;
            end
            // Read data lands in the owner's holding register the cycle before RESP.
            if (w_last_wait && !r_we) begin
                if (r_owner_d) r_d_rdata <= m_rdata;
                else           r_f_rdata <= m_rdata;
            end
        end
    end

endmodule
